// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier (signed/unsigned per transaction) with valid/ready and tag pass-through.
// Define WALLACE_MULT_OCC_EN to add the in-flight counter outputs occ/idle.
module wallace_mult_pipe #(
  parameter int WIDTH      = 16,
  parameter int RED_STAGES = 3,
  parameter int TAG_W      = 4,
  localparam int LAT       = RED_STAGES + $clog2(2*WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [TAG_W-1:0]     out_tag
`ifdef WALLACE_MULT_OCC_EN
  ,
  output logic [$clog2(LAT+1)-1:0] occ,
  output logic                 idle
`endif
);

  localparam int PW = 2*WIDTH;
  localparam int NR = WIDTH + 1;  // WIDTH pp rows plus the Baugh-Wooley constant row
  localparam int LG = $clog2(PW);

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int rows_at(input int k);
    int r;
    r = NR;
    for (int i = 0; i < k; i++) r = (r/3)*2 + r%3;
    return r;
  endfunction

  function automatic int num_layers();
    int r;
    int n;
    r = NR;
    n = 0;
    while (r > 2) begin
      r = (r/3)*2 + r%3;
      n++;
    end
    return n;
  endfunction

  // One Wallace layer: every full group of three rows becomes sum+carry, leftovers pass through.
  function automatic rows_t csa_layer(input rows_t r, input int n);
    rows_t o;
    int g;
    o = '0;
    g = n/3;
    for (int i = 0; i < NR/3; i++)
      if (i < g) begin
        o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
        o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) | (r[3*i+1] & r[3*i+2])) << 1;
      end
    for (int j = 0; j < 2; j++)
      if (j < n%3) o[2*g+j] = r[3*g+j];
    return o;
  endfunction

  localparam int NL = num_layers();

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // valid shift register, bit LAT-1 is the output register
  logic [LAT-1:0] vld_pipe;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else if (adv)   vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
  assign out_valid = vld_pipe[LAT-1];

  // Modified Baugh-Wooley: invert a[n-1]&b[j] and a[i]&b[n-1] (not both), add 2^n + 2^(2n-1)
  rows_t pp;
  always_comb begin
    pp = '0;
    for (int j = 0; j < WIDTH; j++)
      for (int i = 0; i < WIDTH; i++)
        pp[j][i+j] = (a[i] & b[j]) ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
    if (in_signed) begin
      pp[WIDTH][WIDTH] = 1'b1;
      pp[WIDTH][PW-1]  = 1'b1;
    end
  end

  rows_t          red_q [RED_STAGES];
  logic [PW-1:0]  rx_q, ry_q;

  for (genvar s = 0; s < RED_STAGES; s++) begin : g_red
    localparam int LO = s*NL/RED_STAGES;
    localparam int HI = (s+1)*NL/RED_STAGES;
    rows_t lr [HI-LO+1];
    if (s == 0) begin : g_src0
      assign lr[0] = pp;
    end else begin : g_srcn
      assign lr[0] = red_q[s-1];
    end
    for (genvar k = LO; k < HI; k++) begin : g_lay
      assign lr[k-LO+1] = csa_layer(lr[k-LO], rows_at(k));
    end
    if (s == RED_STAGES-1) begin : g_last
      always_ff @(posedge clk)
        if (adv) begin
          rx_q <= lr[HI-LO][0];
          ry_q <= lr[HI-LO][1];
        end
    end else begin : g_mid
      always_ff @(posedge clk)
        if (adv) red_q[s] <= lr[HI-LO];
    end
  end

  // Kogge-Stone carry network, one register per level; ks_q carries the bitwise propagate for the final sum
  logic [PW-1:0] kg_q [LG];
  logic [PW-1:0] ks_q [LG];
  logic [PW-1:0] kp_q [LG-1];

  for (genvar l = 0; l < LG; l++) begin : g_ks
    localparam int D = 2**l;
    logic [PW-1:0] gi, pi, si;
    if (l == 0) begin : g_in
      assign gi = rx_q & ry_q;
      assign pi = rx_q ^ ry_q;
      assign si = pi;
    end else begin : g_prev
      assign gi = kg_q[l-1];
      assign pi = kp_q[l-1];
      assign si = ks_q[l-1];
    end
    always_ff @(posedge clk)
      if (adv) begin
        kg_q[l] <= gi | (pi & (gi << D));
        ks_q[l] <= si;
      end
    if (l < LG-1) begin : g_p
      always_ff @(posedge clk)
        if (adv) kp_q[l] <= pi & (pi << D);
    end
  end

  logic [PW-1:0] sum_w;
  assign sum_w = ks_q[LG-1] ^ (kg_q[LG-1] << 1);

  logic [TAG_W-1:0] tag_q [LAT-1];
  always_ff @(posedge clk)
    if (adv) begin
      tag_q[0] <= in_tag;
      for (int k = 1; k < LAT-1; k++) tag_q[k] <= tag_q[k-1];
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      product <= '0;
      out_tag <= '0;
    end else if (adv) begin
      product <= sum_w;
      out_tag <= tag_q[LAT-2];
    end

`ifdef WALLACE_MULT_OCC_EN
  localparam int OCW = $clog2(LAT+1);
  logic acc, emit;
  assign acc  = in_valid & in_ready;
  assign emit = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              occ <= '0;
    else if (flush)          occ <= '0;
    else if (acc && !emit)   occ <= occ + OCW'(1);
    else if (emit && !acc)   occ <= occ - OCW'(1);
  assign idle = (occ == '0);
`endif

endmodule
